// File: rtl/div_ctrl.sv
// div_ctrl: iterative 32-bit restoring divider controller for the EX stage.
// Accepts DIV/DIVU operands, runs 32 shift-subtract steps, holds the pipeline
// through stall_req_o, and returns {remainder, quotient} for the HI/LO path.
// Optional feature: define DIV_ZERO_FAST_EN to short-circuit a zero divisor
// through the BY_ZERO state (result 0, ready two cycles after accept).
// Without it a zero divisor runs all 32 steps like any other operand.

module div_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        stall_req_o
);

    typedef enum logic [1:0] {
        S_FREE    = 2'd0,
        S_ON      = 2'd1,
        S_END     = 2'd2
`ifdef DIV_ZERO_FAST_EN
        , S_BY_ZERO = 2'd3
`endif
    } state_t;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic [64:0] r_dividend;
    logic [31:0] r_divisor;
    logic        r_sign_q;
    logic        r_sign_r;
    logic [63:0] r_result;
    logic        r_ready;

    logic        w_accept;
    logic        w_busy;
    logic [31:0] w_mag1;
    logic [31:0] w_mag2;
    logic [32:0] w_diff;
    logic [64:0] w_step;
    logic        w_last;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [31:0] w_quot_fix;
    logic [31:0] w_rem_fix;

    // Operand magnitudes: signed operands with bit 31 set are negated.
    // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
    assign w_mag1 = (signed_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
    assign w_mag2 = (signed_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;

    assign w_accept = (r_state == S_FREE) && start_i && !annul_i;

    // One restoring step: trial-subtract the divisor from the upper partial
    // remainder; keep the difference and shift in a 1 when it does not borrow.
    assign w_diff = r_dividend[64:32] - {1'b0, r_divisor};
    assign w_step = w_diff[32] ? {r_dividend[63:0], 1'b0}
                               : {w_diff[31:0], r_dividend[31:0], 1'b1};
    assign w_last = (r_cnt == 6'd31);

    // The final step's outcome is used directly so the result lands on the
    // same edge that enters END.
    assign w_quot     = w_step[31:0];
    assign w_rem      = w_step[64:33];
    assign w_quot_fix = r_sign_q ? -w_quot : w_quot;
    assign w_rem_fix  = r_sign_r ? -w_rem  : w_rem;

`ifdef DIV_ZERO_FAST_EN
    assign w_busy = (r_state == S_ON) || (r_state == S_BY_ZERO);
`else
    assign w_busy = (r_state == S_ON);
`endif

    // Stall is combinational so the request is visible in the accept cycle;
    // it drops in END so the pipeline advances together with the result.
    assign stall_req_o = w_accept || w_busy;
    assign result_o    = r_result;
    assign ready_o     = r_ready;

    // Controller FSM with registered ready/result; reset wins over everything.
    // NOTE: state and datapath registers all use <= so every branch reads the
    // pre-edge values; the datapath is reset too so outputs are clean after rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_FREE;
            r_cnt      <= 6'd0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_sign_q   <= 1'b0;
            r_sign_r   <= 1'b0;
            r_result   <= '0;
            r_ready    <= 1'b0;
        end else begin
            case (r_state)
                S_FREE: begin
                    r_ready <= 1'b0;
                    if (w_accept) begin
                        r_dividend <= {32'd0, w_mag1, 1'b0};
                        r_divisor  <= w_mag2;
                        r_sign_q   <= signed_i & (opdata1_i[31] ^ opdata2_i[31]);
                        r_sign_r   <= signed_i & opdata1_i[31];
                        r_cnt      <= 6'd0;
`ifdef DIV_ZERO_FAST_EN
                        r_state    <= (opdata2_i == 32'd0) ? S_BY_ZERO : S_ON;
`else
                        r_state    <= S_ON;
`endif
                    end
                end
                S_ON: begin
                    if (annul_i) begin
                        r_state <= S_FREE;
                    end else begin
                        r_dividend <= w_step;
                        r_cnt      <= r_cnt + 6'd1;
                        if (w_last) begin
                            r_state  <= S_END;
                            r_ready  <= 1'b1;
                            r_result <= {w_rem_fix, w_quot_fix};
                        end
                    end
                end
`ifdef DIV_ZERO_FAST_EN
                S_BY_ZERO: begin
                    if (annul_i) begin
                        r_state <= S_FREE;
                    end else begin
                        r_state  <= S_END;
                        r_ready  <= 1'b1;
                        r_result <= '0;
                    end
                end
`endif
                S_END: begin
                    // annul is ignored here: the result is already committed.
                    r_ready <= 1'b0;
                    r_state <= S_FREE;
                end
                default: begin
                    r_ready <= 1'b0;
                    r_state <= S_FREE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed boundary cases plus randomized
// DIV/DIVU traffic, compared against an arithmetic reference model.
// Honours DIV_ZERO_FAST_EN the same way the design does.

module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stall_req_o;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [63:0] last_result;

    div_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .signed_i    (signed_i),
        .opdata1_i   (opdata1_i),
        .opdata2_i   (opdata2_i),
        .annul_i     (annul_i),
        .result_o    (result_o),
        .ready_o     (ready_o),
        .stall_req_o (stall_req_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    // Reference: truncating division on magnitudes, then sign fix-up.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        longint unsigned ua, ub;
        logic [31:0] q, r;
        ua = (sgn && a[31]) ? (64'h1_0000_0000 - {32'd0, a}) : {32'd0, a};
        ub = (sgn && b[31]) ? (64'h1_0000_0000 - {32'd0, b}) : {32'd0, b};
        if (ub == 0) begin
`ifdef DIV_ZERO_FAST_EN
            return 64'd0;
`else
            q = 32'hFFFF_FFFF;
            r = ua[31:0];
`endif
        end else begin
            q = 32'(ua / ub);
            r = 32'(ua % ub);
        end
        if (sgn && (a[31] ^ b[31])) q = -q;
        if (sgn && a[31])           r = -r;
        return {r, q};
    endfunction

    function automatic int model_lat(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
        if (b == 32'd0) return 2;
`endif
        return 33;
    endfunction

    // Called just after a rising edge. Presents the request, waits for ready,
    // checks latency, stall profile and result, then steps into the FREE cycle.
    task automatic launch(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input bit keep_start);
        logic [63:0] exp;
        int          exp_lat;
        int          lat;
        int          stall_bad;
        bit          got;
        exp       = model(a, b, sgn);
        exp_lat   = model_lat(b);
        start_i   = 1'b1;
        signed_i  = sgn;
        opdata1_i = a;
        opdata2_i = b;
        annul_i   = 1'b0;
        #1;
        check({tag, "_stall_accept"}, 64'(stall_req_o), 64'd1);
        lat       = 0;
        stall_bad = 0;
        got       = 1'b0;
        while (lat < 40 && !got) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                // operands must be ignored once accepted
                opdata1_i = $urandom;
                opdata2_i = $urandom;
                signed_i  = ~sgn;
            end
            if (ready_o) got = 1'b1;
            else if (!stall_req_o) stall_bad++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_stall_busy"}, 64'(stall_bad), 64'd0);
        check({tag, "_stall_end"}, 64'(stall_req_o), 64'd0);
        check({tag, "_result"}, result_o, exp);
        last_result = exp;
        if (!keep_start) start_i = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_ready_pulse"}, 64'(ready_o), 64'd0);
        check({tag, "_result_hold"}, result_o, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          readies;
        logic [31:0] a, b;
        logic        s;

        rst       = 1'b1;
        start_i   = 1'b0;
        signed_i  = 1'b0;
        opdata1_i = '0;
        opdata2_i = '0;
        annul_i   = 1'b0;
        last_result = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready",  64'(ready_o), 64'd0);
        check("rst_result", result_o,     64'd0);
        check("rst_stall",  64'(stall_req_o), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed cases
        launch("divu_100_7",   32'd100,        32'd7,          1'b0, 1'b0);
        check("divu_100_7_exact", last_result, {32'h2, 32'hE});
        launch("div_m7_2",     32'hFFFF_FFF9,  32'h2,          1'b1, 1'b0);
        launch("div_7_m2",     32'h7,          32'hFFFF_FFFE,  1'b1, 1'b0);
        launch("div_min_m1",   32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 1'b0);
        launch("divu_5_0",     32'd5,          32'd0,          1'b0, 1'b0);
        launch("div_m5_0",     32'hFFFF_FFFB,  32'd0,          1'b1, 1'b0);
        launch("divu_max_1",   32'hFFFF_FFFF,  32'd1,          1'b0, 1'b0);

        // start_i held through END: one pulse, re-accept in the FREE cycle
        launch("hold_a", 32'd1000, 32'd33, 1'b0, 1'b1);
        launch("hold_b", 32'd77,   32'd5,  1'b0, 1'b0);

        // Annul mid-operation
        start_i   = 1'b1;
        signed_i  = 1'b0;
        opdata1_i = 32'd1234;
        opdata2_i = 32'd7;
        repeat (10) @(posedge clk);
        #1;
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check("annul_stall",  64'(stall_req_o), 64'd0);
        check("annul_ready",  64'(ready_o),     64'd0);
        check("annul_result", result_o,         last_result);
        annul_i = 1'b0;
        readies = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready_o) readies++;
        end
        check("annul_no_ready", 64'(readies), 64'd0);
        check("annul_result_late", result_o, last_result);
        launch("divu_9_3", 32'd9, 32'd3, 1'b0, 1'b0);
        check("divu_9_3_exact", last_result, {32'd0, 32'd3});

        // Reset mid-operation
        start_i   = 1'b1;
        signed_i  = 1'b1;
        opdata1_i = 32'hDEAD_BEEF;
        opdata2_i = 32'd13;
        repeat (5) @(posedge clk);
        #1;
        rst     = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_ready",  64'(ready_o),     64'd0);
        check("midrst_result", result_o,         64'd0);
        check("midrst_stall",  64'(stall_req_o), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        launch("after_rst", 32'd50, 32'd6, 1'b0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'($urandom_range(0, 15));
                1:       b = $urandom;
                2:       b = $urandom >> $urandom_range(0, 31);
                default: b = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h8000_0000;
            endcase
            s = 1'($urandom_range(0, 1));
            launch($sformatf("rand%0d", i), a, b, s, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Iterative divider controller for the EX stage. Accepts DIV/DIVU operands from EX, sequences a 32-iteration restoring shift-subtract datapath through a small FSM, and holds the pipeline with a stall request while the operation runs. Returns quotient and remainder for the HI/LO write path.

## Interface
- Parameters: none; data width is fixed at 32.
- Reset is synchronous, active-high, and sampled on the rising edge of `clk`.
- Ports:
  - `clk` in 1: core clock.
  - `rst` in 1: synchronous active-high reset.
  - `start_i` in 1: divide request from EX. Held high until `ready_o` is seen.
  - `signed_i` in 1: 1 = DIV, 0 = DIVU. Sampled at accept.
  - `opdata1_i` in 32: dividend (rs). Sampled at accept.
  - `opdata2_i` in 32: divisor (rt). Sampled at accept.
  - `annul_i` in 1: cancels an in-flight divide (branch flush or exception).
  - `result_o` out 64: {remainder[63:32], quotient[31:0]}. HI gets the remainder, LO gets the quotient.
  - `ready_o` out 1: result valid. High for exactly one cycle.
  - `stall_req_o` out 1: to the pipeline controller; freezes PC/IF/ID/EX.

## Operation
FSM states: FREE, BY_ZERO, ON, END.

- **FREE**
  - If `start_i`=1 and `annul_i`=0, accept the request:
    - latch the operands;
    - if `signed_i`, convert each operand to its magnitude (negate when bit 31 is set) and record sign_q = op1[31]^op2[31] and sign_r = op1[31];
    - load dividend shift register = {32'b0, |op1|, 1'b0}; clear the counter.
  - Next state is BY_ZERO when the divisor is 0 and `DIV_ZERO_FAST_EN` is defined; otherwise ON.
- **ON**
  - Each cycle, one restoring step:
    - t = dividend[64:32] − {1'b0, |op2|};
    - if t[32]=1 (negative), shift left, inserting 0;
    - else dividend = {t[31:0], dividend[31:0], 1'b1}.
  - Counter increments each step; after the 32nd step the next state is END.
  - Quotient = dividend[31:0]; remainder = dividend[64:33].
- **BY_ZERO**
  - Loads the result with 0 and goes to END.
- **END**
  - `ready_o`=1 for one cycle.
  - `result_o` updates on entry to END:
    - signed: quotient is negated if sign_q; remainder is negated if sign_r;
    - unsigned: raw values.
  - Next state is FREE unconditionally. EX must drop `start_i` in the cycle after `ready_o`.
- **Annul**
  - `annul_i`=1 in ON or BY_ZERO returns the FSM to FREE next cycle. `ready_o` stays 0 and `result_o` is unchanged.
  - `annul_i`=1 in FREE blocks the accept.
  - `annul_i` in END is ignored: the result is still presented.
- **Boundary cases**
  - Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 (wrap) and remainder 0.
  - Operand changes after accept are ignored.
  - `start_i` held high in END does not re-trigger; a new accept needs a FREE cycle.

## Timing
- Reset values:
  - state = FREE;
  - `ready_o` = 0;
  - `result_o` = 0;
  - `stall_req_o` = 0;
  - counter = 0.
- `stall_req_o` is combinational: (FREE & `start_i` & ~`annul_i`) | ON | BY_ZERO. It is 0 in END so the pipeline advances with the result.
- Latency, with accept at cycle T:
  - normal divide: ON in T+1..T+32, END/`ready_o` at T+33;
  - fast zero path: BY_ZERO at T+1, END at T+2.
- `result_o` is registered and holds its value until the next END.
- `rst` asserted in any state goes to FREE on the next edge, overriding annul and start.

## Configuration
- **`DIV_ZERO_FAST_EN` defined:** a zero divisor takes the BY_ZERO path. Result = 0, `ready_o` at T+2.
- **`DIV_ZERO_FAST_EN` undefined:** BY_ZERO does not exist and a zero divisor runs all 32 steps. Raw result is quotient 0xFFFFFFFF, remainder = |op1|, with signed sign correction then applied; `ready_o` at T+33.

## Test plan
- **DIVU 100 / 7:** `ready_o` exactly at T+33; result_o = {0x00000002, 0x0000000E}; `stall_req_o` high for T..T+32 and low at T+33.
- **DIV −7 / 2 (0xFFFFFFF9, 0x2):** quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Then DIV 7 / −2: quotient 0xFFFFFFFD, remainder 0x00000001.
- **DIV 0x80000000 / 0xFFFFFFFF:** quotient 0x80000000, remainder 0; no hang.
- **DIVU 5 / 0:**
  - with the macro: `ready_o` at T+2, result 0;
  - without the macro: `ready_o` at T+33, result {0x00000005, 0xFFFFFFFF}.
- **Annul:** `annul_i` pulsed at T+10 → FREE at T+11, `stall_req_o` low, no `ready_o`, `result_o` keeps its previous value. A new DIVU 9 / 3 accepted afterwards completes with {0, 3}.
- **Reset mid-operation:** `rst` high at T+5 → all outputs 0 next edge and state FREE. `start_i` held high through END gives a single `ready_o` pulse, with the re-accept only after the FREE cycle.
